// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, fixed-point formats, FSM states.
// Also used by the rotation-mode cosine unit (Q1.31 entry = ATAN_Q230[i] << 1).
package cordic_pkg;

  localparam int DW      = 32;
  localparam int XY_FRAC = 29;  // x, y are signed Q3.29
  localparam int Z_FRAC  = 30;  // z is signed Q2.30

  localparam logic [DW-1:0] Q1_0 = 32'h2000_0000;

  // round(atan(2^-i) * 2^30)
  localparam logic [DW-1:0] ATAN_Q230 [0:15] = '{
    32'h3243_F6A9, 32'h1DAC_6705, 32'h0FAD_BAFD, 32'h07F5_6EA7,
    32'h03FE_AB77, 32'h01FF_D55C, 32'h00FF_FAAB, 32'h007F_FF55,
    32'h003F_FFEB, 32'h001F_FFFD, 32'h0010_0000, 32'h0008_0000,
    32'h0004_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_8000
  };

  typedef enum logic [1:0] {IDLE, ITER, PACK} state_t;

  // |float| -> Q3.29, truncating; values >= 1.0 (and inf/NaN) clamp to 1.0.
  function automatic logic [DW-1:0] float_to_q329(input logic [30:0] f);
    logic [7:0] e;
    logic [7:0] sh;
    e = f[30:23];
    float_to_q329 = '0;
    if (e == 8'd0)
      float_to_q329 = '0;
    else if (e >= 8'd127)
      float_to_q329 = Q1_0;
    else begin
      sh = 8'd127 - e;
      if (sh < 8'(XY_FRAC + 1))
        float_to_q329 = {2'b00, 1'b1, f[22:0], 6'b0} >> sh;
    end
  endfunction

endpackage

// File: rtl/cordic_fix2float.sv
// Signed Q2.30 to single-precision float, combinational; mantissa truncated.
// No latency and no handshake: the parent registers the output.
module cordic_fix2float
  import cordic_pkg::*;
(
  input  logic [DW-1:0] z,
  output logic [DW-1:0] f
);

  logic [DW-1:0] mag;
  logic [4:0]    lead;
  logic [4:0]    sh;
  logic [7:0]    expo;
  logic [22:0]   mant;

  always_comb begin
    mag  = z[31] ? (~z + 32'd1) : z;
    lead = 5'd0;
    for (int i = 0; i < DW; i++)
      if (mag[i]) lead = 5'(i);
    sh   = 5'd31 - lead;
    // leading one lands on bit 31 and is dropped by the 23-bit truncation
    mant = 23'((mag << sh) >> 8);
    expo = 8'(127 - Z_FRAC) + {3'b000, lead};
    f    = (mag == '0) ? '0 : {z[31], expo, mant};
  end

endmodule

// File: rtl/cordic_atan_vector.sv
// Iterative CORDIC vectoring unit: atan(|y|/|x|) on floats, ITERS+1 cycles start to done.
// No backpressure: start is taken only in IDLE with done low; requests elsewhere are dropped.
module cordic_atan_vector
  import cordic_pkg::*;
#(
  parameter int ITERS = 16
) (
  input  logic          clock,
  input  logic          aclr,
  input  logic          clk_en,
  input  logic          start,
  input  logic [DW-1:0] dataa,
  input  logic [DW-1:0] datab,
  output logic [DW-1:0] result,
  output logic          done
);

  state_t state, state_nxt;

  logic [3:0]    iter;
  logic [DW-1:0] x, y, z;
  logic [DW-1:0] x_sh, y_sh, angle;
  logic [DW-1:0] x_in, y_in;
  logic [DW-1:0] z_float;
  logic          zero_op;
  logic          load, step, pack;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr)
      state <= IDLE;
    else if (clk_en)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !done) state_nxt = ITER;
      ITER:    if (iter == 4'(ITERS - 1)) state_nxt = PACK;
      PACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // start is also refused while done is still high, so a request issued on the
  // completion pulse is dropped rather than starting a back-to-back operation
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    pack = 1'b0;
    case (state)
      IDLE:    load = start && !done;
      ITER:    step = 1'b1;
      PACK:    pack = 1'b1;
      default: ;
    endcase
  end

  assign x_in  = float_to_q329(dataa[30:0]);
  assign y_in  = float_to_q329(datab[30:0]);
  assign x_sh  = $signed(x) >>> iter;
  assign y_sh  = $signed(y) >>> iter;
  assign angle = ATAN_Q230[iter];

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      iter    <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      zero_op <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
    end else if (clk_en) begin
      done <= pack;
      if (load) begin
        x       <= x_in;
        y       <= y_in;
        z       <= '0;
        iter    <= '0;
        zero_op <= (x_in == '0) && (y_in == '0);
      end else if (step) begin
        iter <= iter + 4'd1;
        if (!y[31]) begin
          x <= x + y_sh;
          y <= y - x_sh;
          z <= z + angle;
        end else begin
          x <= x - y_sh;
          y <= y + x_sh;
          z <= z - angle;
        end
      end
      if (pack)
        result <= zero_op ? '0 : z_float;
    end
  end

  cordic_fix2float u_fix2float (
    .z (z),
    .f (z_float)
  );

endmodule

// File: tb/tb_cordic_atan_vector.sv
// Directed bench for cordic_atan_vector: latency, accuracy, start filtering, clk_en stall, async clear.
module tb_cordic_atan_vector;

  logic        clock  = 1'b0;
  logic        aclr   = 1'b1;
  logic        clk_en = 1'b1;
  logic        start  = 1'b0;
  logic [31:0] dataa  = '0;
  logic [31:0] datab  = '0;
  logic [31:0] result;
  logic        done;

  int checks = 0;
  int passes = 0;
  int n;
  int lat;

  localparam logic [31:0] F_ONE  = 32'h3F80_0000;
  localparam logic [31:0] F_HALF = 32'h3F00_0000;
  localparam logic [31:0] F_C30  = 32'h3F5D_B3D7;
  localparam real TOL = 1.0e-4;

  cordic_atan_vector #(.ITERS(16)) dut (
    .clock  (clock),
    .aclr   (aclr),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .datab  (datab),
    .result (result),
    .done   (done)
  );

  always #5 clock = ~clock;

  function automatic real f2r(input logic [31:0] b);
    int  e;
    real r;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    while (e > 127) begin r = r * 2.0; e--; end
    while (e < 127) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs, input real want);
    real   got;
    logic  ok;
    got = f2r(obs);
    ok  = ((got - want) <= TOL) && ((want - got) <= TOL);
    checks++;
    assert (ok === 1'b1) passes++;
    else $error("FAIL %s observed=%h (%f) expected=%f +/- 1e-4", tag, obs, got, want);
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(posedge clock); #1;
    dataa = a; datab = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // returns the number of edges until done is seen, 0 if the budget expires
  task automatic wait_done(input int budget, output int cnt);
    cnt = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clock); #1;
      if (done) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    #12;
    chk("reset_result", result, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    aclr = 1'b0;

    // atan(1/1)
    launch(F_ONE, F_ONE);
    wait_done(40, n);
    chk("lat_1_1", n, 32'd17);
    chk_near("atan_1_1", result, 0.785398);
    @(posedge clock); #1;
    chk("done_one_cycle", {31'b0, done}, 32'h0);

    // 30 degrees, then x=0 gives pi/2
    launch(F_C30, F_HALF);
    wait_done(40, n);
    chk("lat_30deg", n, 32'd17);
    chk_near("atan_30deg", result, 0.523599);
    launch(32'h0, F_HALF);
    wait_done(40, n);
    chk_near("atan_x0", result, 1.570796);

    // y=0 and the both-zero case
    launch(F_HALF, 32'h0);
    wait_done(40, n);
    chk_near("atan_y0", result, 0.0);
    launch(32'h0, 32'h0);
    wait_done(40, n);
    chk("lat_zero", n, 32'd17);
    chk("atan_zero", result, 32'h0);

    // start held high through ITER with other operands must be ignored
    @(posedge clock); #1;
    dataa = F_ONE; datab = F_ONE; start = 1'b1;
    @(posedge clock); #1;
    dataa = 32'h0; datab = F_HALF;
    for (int i = 0; i < 14; i++) @(posedge clock);
    #1 start = 1'b0;
    wait_done(40, n);
    chk("lat_restart", n + 14, 32'd17);
    chk_near("atan_restart", result, 0.785398);
    // a request on the done pulse itself is dropped
    dataa = 32'h0; datab = F_HALF; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(30, n);
    chk("no_extra_done", n, 32'd0);
    chk_near("result_held", result, 0.785398);

    // 5 disabled cycles mid-ITER add 5 cycles of latency
    launch(F_C30, F_HALF);
    for (int i = 0; i < 4; i++) @(posedge clock);
    #1 clk_en = 1'b0;
    for (int i = 0; i < 5; i++) @(posedge clock);
    #1;
    chk("done_frozen", {31'b0, done}, 32'h0);
    clk_en = 1'b1;
    wait_done(40, n);
    lat = 9 + n;
    chk("lat_stall", lat, 32'd22);
    chk_near("atan_stall", result, 0.523599);

    // asynchronous clear mid-ITER
    launch(F_ONE, F_ONE);
    for (int i = 0; i < 5; i++) @(posedge clock);
    #3 aclr = 1'b1;
    #1;
    chk("aclr_result", result, 32'h0);
    chk("aclr_done", {31'b0, done}, 32'h0);
    #2 aclr = 1'b0;
    wait_done(30, n);
    chk("aclr_no_stale_done", n, 32'd0);
    launch(F_C30, F_HALF);
    wait_done(40, n);
    chk("lat_after_aclr", n, 32'd17);
    chk_near("atan_after_aclr", result, 0.523599);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
